// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator-mode entry sequencer.
package calc_pkg;

    localparam int unsigned MAX_VAL = 9999;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_EQ  = 4'hD;
    localparam logic [3:0] BCD_ERR = 4'hE;

    typedef enum logic [2:0] {
        S_A   = 3'd0,
        S_OP  = 3'd1,
        S_B   = 3'd2,
        S_RES = 3'd3,
        S_ERR = 3'd4
    } state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] code);
        return (code == KEY_ADD) || (code == KEY_SUB);
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter. The first shift is folded into
// the load so busy spans WIDTH+1 cycles from the start cycle through the done cycle.
module bin2bcd_seq #(
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             running_q;
    logic             done_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] bin_q;
    logic [15:0]      acc_q;

    logic [WIDTH-1:0] src_bin;
    logic [WIDTH-1:0] bin_n;
    logic [15:0]      src_acc;
    logic [15:0]      adj;
    logic [15:0]      acc_n;

    always_comb begin
        src_acc = start ? 16'h0000 : acc_q;
        src_bin = start ? bin : bin_q;
        adj     = src_acc;
        for (int i = 0; i < 4; i++) begin
            if (src_acc[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = src_acc[4*i +: 4] + 4'd3;
            end
        end
        acc_n = {adj[14:0], src_bin[WIDTH-1]};
        bin_n = {src_bin[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            bin_q     <= '0;
            acc_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                running_q <= 1'b1;
                cnt_q     <= CW'(1);
                acc_q     <= acc_n;
                bin_q     <= bin_n;
            end else if (running_q) begin
                acc_q <= acc_n;
                bin_q <= bin_n;
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign busy = start | running_q | done_q;
    assign done = done_q;
    // Only meaningful while done is high; the top latches it then.
    assign bcd  = acc_q;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator-mode sequencer: keypad events build two operands, add/sub them and
// feed the four 7-seg BCD digits through a sequential binary-to-BCD converter.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH   = 14,
    parameter int unsigned MAX_VAL = 9999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_down,
    input  logic [3:0] key_code,
    output logic [3:0] bcd_thousands,
    output logic [3:0] bcd_hundreds,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_units,
    output logic       negative,
    output logic       error,
    output logic       busy,
    output logic [2:0] mode
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [WIDTH-1:0] disp, disp_q;
    logic             sub_q, sub_d, neg_q, neg_d, err_q, err_d;
    logic             restart_q, restart_d;
    logic             key_q;
    logic [15:0]      shown_q;

    logic             key_edge, ev, clr, start;
    logic             conv_busy, conv_done;
    logic [15:0]      conv_bcd, shown;
    logic [WIDTH:0]   sum;

    function automatic logic [WIDTH-1:0] append_digit(input logic [WIDTH-1:0] acc,
                                                      input logic [3:0] d);
        logic [WIDTH+3:0] wide;
        wide = ({4'b0, acc} * (WIDTH+4)'(10)) + {{WIDTH{1'b0}}, d};
        return (acc < WIDTH'(1000)) ? wide[WIDTH-1:0] : acc;
    endfunction

    assign key_edge = key_down & ~key_q;
    assign clr      = key_edge && (key_code == KEY_CLR);
    assign ev       = key_edge && !conv_busy;
    assign sum      = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        unique case (state_q)
            S_B:          disp = b_q;
            S_RES, S_ERR: disp = res_q;
            default:      disp = a_q;
        endcase
    end

    // Errors freeze the converter; clear forces a fresh conversion even if 0 is shown.
    assign start = (state_q != S_ERR) && ((disp != disp_q) || restart_q);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        sub_d     = sub_q;
        neg_d     = neg_q;
        err_d     = err_q;
        restart_d = 1'b0;
        if (clr) begin
            state_d   = S_A;
            a_d       = '0;
            b_d       = '0;
            neg_d     = 1'b0;
            err_d     = 1'b0;
            restart_d = 1'b1;
        end else if (ev) begin
            unique case (state_q)
                S_A: begin
                    if (is_digit(key_code)) begin
                        a_d = append_digit(a_q, key_code);
                    end else if (is_op(key_code)) begin
                        sub_d   = (key_code == KEY_SUB);
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    if (is_digit(key_code)) begin
                        b_d     = WIDTH'(key_code);
                        state_d = S_B;
                    end else if (is_op(key_code)) begin
                        sub_d = (key_code == KEY_SUB);
                    end else if (key_code == KEY_EQ) begin
                        res_d   = a_q;
                        neg_d   = 1'b0;
                        state_d = S_RES;
                    end
                end
                S_B: begin
                    if (is_digit(key_code)) begin
                        b_d = append_digit(b_q, key_code);
                    end else if (key_code == KEY_EQ) begin
                        if (!sub_q && (sum > (WIDTH+1)'(MAX_VAL))) begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end else if (!sub_q) begin
                            res_d   = sum[WIDTH-1:0];
                            neg_d   = 1'b0;
                            state_d = S_RES;
                        end else if (a_q >= b_q) begin
                            res_d   = a_q - b_q;
                            neg_d   = 1'b0;
                            state_d = S_RES;
                        end else begin
                            res_d   = b_q - a_q;
                            neg_d   = 1'b1;
                            state_d = S_RES;
                        end
                    end
                end
                S_RES: begin
                    if (is_digit(key_code)) begin
                        a_d     = WIDTH'(key_code);
                        b_d     = '0;
                        neg_d   = 1'b0;
                        state_d = S_A;
                    end else if (is_op(key_code) && !neg_q) begin
                        a_d     = res_q;
                        b_d     = '0;
                        sub_d   = (key_code == KEY_SUB);
                        state_d = S_OP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            sub_q     <= 1'b0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
            restart_q <= 1'b0;
            key_q     <= 1'b0;
            disp_q    <= '0;
            shown_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            sub_q     <= sub_d;
            neg_q     <= neg_d;
            err_q     <= err_d;
            restart_q <= restart_d;
            key_q     <= key_down;
            disp_q    <= disp;
            if (conv_done) begin
                shown_q <= conv_bcd;
            end
        end
    end

    bin2bcd_seq #(
        .WIDTH (WIDTH)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (disp),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign shown         = conv_done ? conv_bcd : shown_q;
    assign bcd_thousands = err_q ? BCD_ERR : shown[15:12];
    assign bcd_hundreds  = err_q ? BCD_ERR : shown[11:8];
    assign bcd_tens      = err_q ? BCD_ERR : shown[7:4];
    assign bcd_units     = err_q ? BCD_ERR : shown[3:0];
    assign negative      = neg_q;
    assign error         = err_q;
    assign busy          = conv_busy;
    assign mode          = state_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: key sequences with hand-computed displays.
module tb_calc_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_down;
    logic [3:0] key_code;
    logic [3:0] bcd_thousands, bcd_hundreds, bcd_tens, bcd_units;
    logic       negative, error, busy;
    logic [2:0] mode;
    logic [15:0] disp;

    int tests = 0;
    int fails = 0;
    int busy_cycles;

    calc_entry_ctrl #(
        .WIDTH   (14),
        .MAX_VAL (9999)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_down      (key_down),
        .key_code      (key_code),
        .bcd_thousands (bcd_thousands),
        .bcd_hundreds  (bcd_hundreds),
        .bcd_tens      (bcd_tens),
        .bcd_units     (bcd_units),
        .negative      (negative),
        .error         (error),
        .busy          (busy),
        .mode          (mode)
    );

    always #5 clk = ~clk;

    assign disp = {bcd_thousands, bcd_hundreds, bcd_tens, bcd_units};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Hold the key for 'hold' cycles, release, then watch busy for 'gap' cycles.
    task automatic press(input logic [3:0] code, input int hold, input int gap);
        @(negedge clk);
        key_down = 1'b1;
        key_code = code;
        repeat (hold) @(negedge clk);
        key_down    = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < gap; i++) begin
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst      = 1'b1;
        key_down = 1'b0;
        key_code = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_bcd", disp, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_neg", negative, 0);
        check("rst_mode", mode, 0);

        // digit entry and conversion busy window
        press(4'h1, 1, 24);
        check("d1_bcd", disp, 16'h0001);
        check("d1_busy_w", busy_cycles, 15);
        press(4'h2, 1, 24);
        check("d12_bcd", disp, 16'h0012);
        check("d12_busy_w", busy_cycles, 15);
        press(4'h3, 1, 24);
        check("d123_bcd", disp, 16'h0123);
        check("d123_busy_w", busy_cycles, 15);

        // 12 + 34 = 46
        press(4'hC, 1, 24);
        check("clr_bcd", disp, 16'h0000);
        press(4'h1, 1, 24);
        press(4'h2, 1, 24);
        press(4'hA, 1, 24);
        check("op_mode", mode, 1);
        check("op_bcd", disp, 16'h0012);
        press(4'h3, 1, 24);
        check("b_mode", mode, 2);
        check("b_bcd", disp, 16'h0003);
        press(4'h4, 1, 24);
        press(4'hD, 1, 24);
        check("add_bcd", disp, 16'h0046);
        check("add_neg", negative, 0);
        check("add_mode", mode, 3);

        // 5 - 12 = -7
        press(4'h5, 1, 24);
        check("res_dig_bcd", disp, 16'h0005);
        check("res_dig_mode", mode, 0);
        press(4'hB, 1, 24);
        press(4'h1, 1, 24);
        press(4'h2, 1, 24);
        press(4'hD, 1, 24);
        check("sub_bcd", disp, 16'h0007);
        check("sub_neg", negative, 1);

        // op after a negative result is ignored
        press(4'hA, 1, 24);
        check("neg_op_mode", mode, 3);

        // 9999 + 1 overflows
        press(4'h9, 1, 24);
        check("neg_clr_on_dig", negative, 0);
        press(4'h9, 1, 24);
        press(4'h9, 1, 24);
        press(4'h9, 1, 24);
        check("a9999_bcd", disp, 16'h9999);
        press(4'hA, 1, 24);
        press(4'h1, 1, 24);
        press(4'hD, 1, 24);
        check("ovf_err", error, 1);
        check("ovf_bcd", disp, 16'hEEEE);
        check("ovf_mode", mode, 4);
        check("ovf_busy", busy, 0);
        press(4'h7, 1, 24);
        check("err_ign_bcd", disp, 16'hEEEE);
        check("err_ign_mode", mode, 4);
        press(4'hC, 1, 24);
        check("err_clr_err", error, 0);
        check("err_clr_bcd", disp, 16'h0000);
        check("err_clr_mode", mode, 0);

        // fifth digit dropped
        press(4'h1, 1, 24);
        press(4'h2, 1, 24);
        press(4'h3, 1, 24);
        press(4'h4, 1, 24);
        press(4'h5, 1, 24);
        check("max4_bcd", disp, 16'h1234);

        // held key is one event
        press(4'hC, 1, 24);
        press(4'h7, 100, 24);
        check("hold_bcd", disp, 16'h0007);
        press(4'h8, 1, 24);
        check("hold_next_bcd", disp, 16'h0078);

        // key during busy dropped; clear during busy restarts to 0
        press(4'hC, 1, 24);
        press(4'h3, 1, 0);
        repeat (3) @(negedge clk);
        press(4'h4, 1, 24);
        check("busy_drop_bcd", disp, 16'h0003);
        press(4'h5, 1, 0);
        repeat (3) @(negedge clk);
        check("mid_conv_hold", disp, 16'h0003);
        check("mid_conv_busy", busy, 1);
        press(4'hC, 1, 24);
        check("busy_clr_bcd", disp, 16'h0000);
        check("busy_clr_busy", busy, 0);
        check("busy_clr_mode", mode, 0);
        press(4'h6, 1, 24);
        check("after_clr_bcd", disp, 16'h0006);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
